// File: rtl/joypad_serial_reader.sv
`default_nettype none
// ============================================================================
//  Module   : joypad_serial_reader
//  Purpose  : Polls a SNES-style serial pad on a fixed cadence. Drives the
//             latch and shift-clock lines, shifts in the 16-bit report and
//             publishes an active-high parallel button word, per-button press
//             ticks and a one-cycle update strobe.
//  Ports    : clock               - system clock (only clock in the block)
//             reset               - synchronous, active-high reset
//             padData             - serial data from pad, active low, async
//             padLatch            - latch strobe to pad (high loads pad)
//             padClock            - shift clock to pad, idles high
//             buttons[15:0]       - active-high button state
//             buttonsPressed_tick - one-cycle 0->1 edge flags per button
//             sampleValid         - one-cycle strobe when buttons updates
//  Params   : CLOCK_DIV     - cycles per padClock half period (>= 4)
//             LATCH_CYCLES  - cycles padLatch is held high
//             POLL_INTERVAL - cycles between poll starts
//                             (> LATCH_CYCLES + 32*CLOCK_DIV + 2)
//  Revision : 1.0 - initial release
// ============================================================================
module joypad_serial_reader #(
    parameter int CLOCK_DIV     = 300,
    parameter int LATCH_CYCLES  = 600,
    parameter int POLL_INTERVAL = 833333
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        padData,
    output logic        padLatch,
    output logic        padClock,
    output logic [15:0] buttons,
    output logic [15:0] buttonsPressed_tick,
    output logic        sampleValid
);

    localparam int c_CNT_MAX = (LATCH_CYCLES > CLOCK_DIV) ? LATCH_CYCLES : CLOCK_DIV;
    localparam int c_CNT_W   = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_TIMER_W = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;

    localparam logic [c_CNT_W-1:0]   c_LATCH_LAST   = c_CNT_W'(LATCH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_DIV_LAST     = c_CNT_W'(CLOCK_DIV - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_RELOAD = c_TIMER_W'(POLL_INTERVAL - 1);
    localparam logic [3:0]           c_LAST_BIT     = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LATCH      = 3'd1,
        S_SHIFT_LOW  = 3'd2,
        S_SHIFT_HIGH = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_TIMER_W-1:0]   w_timerNext;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cntNext;
    logic [3:0]             r_idx;
    logic [3:0]             w_idxNext;
    logic [15:0]            r_capture;
    logic [15:0]            w_captureNext;
    logic                   r_padSync1;
    logic                   r_padSync2;

    // ------------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        w_nextState   = r_state;
        w_cntNext     = r_cnt + 1'b1;
        w_idxNext     = r_idx;
        w_captureNext = r_capture;
        // Timer free-runs down to zero and parks there; an expiry while busy
        // is simply picked up once the FSM is back in IDLE.
        w_timerNext   = (r_timer == '0) ? r_timer : (r_timer - 1'b1);

        case (r_state)
            S_IDLE: begin
                w_cntNext = '0;
                if (r_timer == '0) begin
                    w_nextState = S_LATCH;
                    w_timerNext = c_TIMER_RELOAD;
                end
            end
            S_LATCH: begin
                if (r_cnt == c_LATCH_LAST) begin
                    w_nextState = S_SHIFT_LOW;
                    w_cntNext   = '0;
                    w_idxNext   = '0;
                end
            end
            S_SHIFT_LOW: begin
                // Sample at the end of the low phase: the pad changed its
                // output a full half period earlier, so the synchronizer
                // output has long settled.
                if (r_cnt == c_DIV_LAST) begin
                    w_captureNext[r_idx] = r_padSync2;
                    w_nextState          = S_SHIFT_HIGH;
                    w_cntNext            = '0;
                end
            end
            S_SHIFT_HIGH: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cntNext = '0;
                    if (r_idx == c_LAST_BIT) begin
                        w_nextState = S_DONE;
                    end else begin
                        w_idxNext   = r_idx + 4'd1;
                        w_nextState = S_SHIFT_LOW;
                    end
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
                w_cntNext   = '0;
            end
            default: begin
                w_nextState = S_IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state             <= S_IDLE;
            r_timer             <= '0;
            r_cnt               <= '0;
            r_idx               <= '0;
            r_capture           <= '1;
            r_padSync1          <= 1'b1;
            r_padSync2          <= 1'b1;
            padLatch            <= 1'b0;
            padClock            <= 1'b1;
            buttons             <= '0;
            buttonsPressed_tick <= '0;
            sampleValid         <= 1'b0;
        end else begin
            r_padSync1 <= padData;
            r_padSync2 <= r_padSync1;
            r_state    <= w_nextState;
            r_timer    <= w_timerNext;
            r_cnt      <= w_cntNext;
            r_idx      <= w_idxNext;
            r_capture  <= w_captureNext;

            // Pad lines are registered from the next state so they line up
            // exactly with the state occupancy and cannot glitch.
            padLatch <= (w_nextState == S_LATCH);
            padClock <= (w_nextState != S_SHIFT_LOW);

            // The result registers load on entry to DONE so that the new
            // word, its edge flags and the strobe are all visible during
            // the DONE cycle. The capture is already complete here since the
            // last bit was taken at the end of the final low phase.
            if (w_nextState == S_DONE) begin
                buttons             <= ~r_capture;
                buttonsPressed_tick <= ~r_capture & ~buttons;
                sampleValid         <= 1'b1;
            end else begin
                buttonsPressed_tick <= '0;
                sampleValid         <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_joypad_serial_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_joypad_serial_reader
//  Purpose  : Self-checking bench for joypad_serial_reader with a behavioural
//             pad model, an expectation queue and a free-running monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_joypad_serial_reader;

    localparam int CD     = 4;
    localparam int LC     = 8;
    localparam int PI     = 200;
    localparam int SV_LAT = LC + 32 * CD;   // latch rise -> sampleValid

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        padData = 1'b1;
    logic        padLatch;
    logic        padClock;
    logic [15:0] buttons;
    logic [15:0] buttonsPressed_tick;
    logic        sampleValid;

    joypad_serial_reader #(
        .CLOCK_DIV    (CD),
        .LATCH_CYCLES (LC),
        .POLL_INTERVAL(PI)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .padData            (padData),
        .padLatch           (padLatch),
        .padClock           (padClock),
        .buttons            (buttons),
        .buttonsPressed_tick(buttonsPressed_tick),
        .sampleValid        (sampleValid)
    );

    always #5 clock = ~clock;

    int   cyc = 0;
    logic resetSampled = 1'b1;
    always @(posedge clock) begin
        cyc          <= cyc + 1;
        resetSampled <= reset;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Pad model: parallel load while latched, shift on each padClock rise,
    // bit 0 presented first, ones shifted in behind the report.
    // ------------------------------------------------------------------------
    logic [15:0] padRaw = 16'hFFFF;
    logic [15:0] padSr  = 16'hFFFF;
    logic        padPrevClk = 1'b1;
    always @(negedge clock) begin
        if (padLatch === 1'b1)
            padSr = padRaw;
        else if (padClock === 1'b1 && padPrevClk === 1'b0)
            padSr = {1'b1, padSr[15:1]};
        padPrevClk = padClock;
        padData    = padSr[0];
    end

    // ------------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [15:0] btn;
        logic [15:0] tick;
    } exp_t;

    exp_t        expQ[$];
    logic [15:0] modelButtons = 16'h0000;

    task automatic issuePoll(input logic [15:0] raw);
        exp_t e;
        padRaw       = raw;
        e.btn        = ~raw;
        e.tick       = ~raw & ~modelButtons;
        modelButtons = ~raw;
        expQ.push_back(e);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: pad-line timing, strobe latency and scoreboard pops
    // ------------------------------------------------------------------------
    int   lastRise = 0;
    bit   firstAfterReset = 1'b0;
    int   releaseCycle = 0;
    int   lowLen = 0;
    int   lowPulses = 0;
    int   latchLen = 0;
    logic monPrevLatch = 1'b0;
    logic monPrevClk = 1'b1;

    always @(negedge clock) begin
        exp_t e;
        if (resetSampled) begin
            lowLen    = 0;
            lowPulses = 0;
            latchLen  = 0;
        end else begin
            if (padLatch && !monPrevLatch) begin
                if (firstAfterReset)
                    check("latch_start_after_reset", 64'(cyc), 64'(releaseCycle + 1));
                else
                    check("poll_cadence", 64'(cyc), 64'(lastRise + PI));
                firstAfterReset = 1'b0;
                lastRise  = cyc;
                lowPulses = 0;
                latchLen  = 0;
            end
            if (padLatch) latchLen++;
            if (!padLatch && monPrevLatch) check("latch_width", 64'(latchLen), 64'(LC));
            if (!padClock) lowLen++;
            if (padClock && !monPrevClk) begin
                check("clk_low_width", 64'(lowLen), 64'(CD));
                lowPulses++;
                lowLen = 0;
            end
            if (sampleValid) begin
                check("valid_latency", 64'(cyc), 64'(lastRise + SV_LAT));
                check("low_pulse_count", 64'(lowPulses), 64'd16);
                if (expQ.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    check("buttons", 64'(buttons), 64'(e.btn));
                    check("press_tick", 64'(buttonsPressed_tick), 64'(e.tick));
                end
            end else begin
                check("tick_idle", 64'(buttonsPressed_tick), 64'd0);
            end
        end
        monPrevLatch = padLatch;
        monPrevClk   = padClock;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic waitValid();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!sampleValid && n < 400);
        if (!sampleValid) check("valid_timeout", 64'd0, 64'd1);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [15:0] raw;
        logic [15:0] prevRaw;
        int          falls;
        int          n;
        logic        prevClk;

        reset = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("reset_outputs",
                  {29'd0, padLatch, padClock, sampleValid, buttons, buttonsPressed_tick},
                  {29'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000});
        end

        // First poll, nothing pressed
        issuePoll(16'hFFFF);
        reset           = 1'b0;
        releaseCycle    = cyc;
        firstAfterReset = 1'b1;
        waitValid();
        check("first_valid_cycle", 64'(cyc), 64'(releaseCycle + 1 + SV_LAT));
        check("first_buttons", 64'(buttons), 64'h0000);

        // B + Start pressed, twice, then B released / A pressed
        issuePoll(16'hFFF6);
        waitValid();
        check("bstart_buttons", 64'(buttons), 64'h0009);
        check("bstart_tick", 64'(buttonsPressed_tick), 64'h0009);
        issuePoll(16'hFFF6);
        waitValid();
        check("bstart_hold_tick", 64'(buttonsPressed_tick), 64'h0000);
        issuePoll(16'hFEF7);
        waitValid();
        check("a_buttons", 64'(buttons), 64'h0108);
        check("a_tick", 64'(buttonsPressed_tick), 64'h0100);

        // Randomized polls, some repeating the previous report
        prevRaw = 16'hFEF7;
        for (int i = 0; i < 8; i++) begin
            raw = (i % 3 == 2) ? prevRaw : 16'($urandom());
            issuePoll(raw);
            waitValid();
            prevRaw = raw;
        end

        // Abort a poll with reset during the bit 7 low phase
        issuePoll(16'($urandom()));
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!padLatch && n < 400);
        if (!padLatch) check("abort_latch_timeout", 64'd0, 64'd1);
        falls   = 0;
        prevClk = padClock;
        n       = 0;
        while (falls < 8 && n < 400) begin
            @(negedge clock);
            n++;
            if (!padClock && prevClk) falls++;
            prevClk = padClock;
        end
        if (falls < 8) check("abort_bit7_timeout", 64'(falls), 64'd8);
        @(negedge clock);
        reset = 1'b1;
        expQ.delete();
        modelButtons = 16'h0000;
        @(negedge clock);
        reset           = 1'b0;
        releaseCycle    = cyc;
        firstAfterReset = 1'b1;
        check("abort_outputs",
              {29'd0, padLatch, padClock, sampleValid, buttons, buttonsPressed_tick},
              {29'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000});
        raw = 16'($urandom());
        issuePoll(raw);
        waitValid();
        check("post_abort_valid_cycle", 64'(cyc), 64'(releaseCycle + 1 + SV_LAT));

        for (int i = 0; i < 3; i++) begin
            issuePoll(16'($urandom()));
            waitValid();
        end

        repeat (5) @(negedge clock);
        check("scoreboard_drained", 64'(expQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
